// File: rtl/counter_checker.sv
// rtl/counter_checker.sv - shadow-model monitor for the 4-bit up/down loadable counter
// Tracks the expected count and reports mismatches, wrap pulses and the first failure.
module counter_checker #(
  parameter int WIDTH       = 4,
  parameter int ERR_CNT_W   = 8,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 chk_en,
  input  logic                 clr_err,
  input  logic                 load,
  input  logic                 updown,
  input  logic [WIDTH-1:0]     data,
  input  logic [WIDTH-1:0]     cnt_obs,
  output logic [WIDTH-1:0]     exp_cnt,
  output logic                 mismatch,
  output logic                 err_flag,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [WIDTH-1:0]     first_exp,
  output logic [WIDTH-1:0]     first_obs,
  output logic                 wrap,
  output logic [1:0]           state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0]     V_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]     V_MAX   = {WIDTH{1'b1}};
  localparam logic [ERR_CNT_W-1:0] E_ONE   = {{(ERR_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [ERR_CNT_W-1:0] E_MAX   = {ERR_CNT_W{1'b1}};

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     exp_q, exp_d;
  logic                 mm_q, mm_d;
  logic                 wrap_q, wrap_d;
  logic                 flag_q, flag_d;
  logic [ERR_CNT_W-1:0] ecnt_q, ecnt_d;
  logic [WIDTH-1:0]     fexp_q, fexp_d;
  logic [WIDTH-1:0]     fobs_q, fobs_d;

  // The counter's own next-value rule; load outranks direction.
  function automatic logic [WIDTH-1:0] next_val(input logic [WIDTH-1:0] v, input logic ld,
                                                input logic up, input logic [WIDTH-1:0] d);
    if (ld) return d;
    return up ? v + V_ONE : v - V_ONE;
  endfunction

  function automatic logic wraps(input logic [WIDTH-1:0] v, input logic ld, input logic up);
    return !ld && (up ? (v == V_MAX) : (v == '0));
  endfunction

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    mm_d    = 1'b0;
    wrap_d  = 1'b0;
    flag_d  = flag_q;
    ecnt_d  = ecnt_q;
    fexp_d  = fexp_q;
    fobs_d  = fobs_q;
    case (state_q)
      IDLE: begin
        exp_d = next_val(cnt_obs, load, updown, data);
        if (chk_en) state_d = TRACK;
      end
      TRACK: begin
        if (!chk_en) begin
          state_d = IDLE;
          exp_d   = next_val(cnt_obs, load, updown, data);
        end else if (cnt_obs == exp_q) begin
          exp_d  = next_val(exp_q, load, updown, data);
          wrap_d = wraps(exp_q, load, updown);
        end else begin
          mm_d   = 1'b1;
          flag_d = 1'b1;
          if (ecnt_q != E_MAX) ecnt_d = ecnt_q + E_ONE;
          if (!flag_q) begin
            fexp_d = exp_q;
            fobs_d = cnt_obs;
          end
          // Resync from the observed value so one corruption yields one error.
          if (STOP_ON_ERR) begin
            state_d = HALT;
          end else begin
            exp_d  = next_val(cnt_obs, load, updown, data);
            wrap_d = wraps(cnt_obs, load, updown);
          end
        end
      end
      HALT: begin
      end
      default: state_d = IDLE;
    endcase
    // Clear wins over a same-edge mismatch, but the pulse itself still fires.
    if (clr_err) begin
      ecnt_d = '0;
      flag_d = 1'b0;
      fexp_d = '0;
      fobs_d = '0;
      if (state_d == HALT) state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      exp_q   <= '0;
      mm_q    <= 1'b0;
      wrap_q  <= 1'b0;
      flag_q  <= 1'b0;
      ecnt_q  <= '0;
      fexp_q  <= '0;
      fobs_q  <= '0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      mm_q    <= mm_d;
      wrap_q  <= wrap_d;
      flag_q  <= flag_d;
      ecnt_q  <= ecnt_d;
      fexp_q  <= fexp_d;
      fobs_q  <= fobs_d;
    end
  end

  assign state     = state_q;
  assign exp_cnt   = exp_q;
  assign mismatch  = mm_q;
  assign wrap      = wrap_q;
  assign err_flag  = flag_q;
  assign err_count = ecnt_q;
  assign first_exp = fexp_q;
  assign first_obs = fobs_q;

endmodule

// File: tb/tb_counter_checker.sv
// tb/tb_counter_checker.sv - randomized bench for counter_checker against a reference model
module tb_counter_checker;

  logic       clk = 1'b0;
  logic       rst, chk_en, clr_err, load, updown;
  logic [3:0] data, cnt_obs;

  logic [3:0] exp0, fe0, fo0, exp1, fe1, fo1;
  logic       mm0, wr0, fl0, mm1, wr1, fl1;
  logic [7:0] ec0, ec1;
  logic [1:0] st0, st1;

  int n_checks = 0;
  int n_pass   = 0;
  int wraps0   = 0;

  always #5 clk = ~clk;

  counter_checker #(.WIDTH(4), .ERR_CNT_W(8), .STOP_ON_ERR(1'b0)) u_run (
    .clk(clk), .rst(rst), .chk_en(chk_en), .clr_err(clr_err), .load(load), .updown(updown),
    .data(data), .cnt_obs(cnt_obs), .exp_cnt(exp0), .mismatch(mm0), .err_flag(fl0),
    .err_count(ec0), .first_exp(fe0), .first_obs(fo0), .wrap(wr0), .state(st0));

  counter_checker #(.WIDTH(4), .ERR_CNT_W(8), .STOP_ON_ERR(1'b1)) u_halt (
    .clk(clk), .rst(rst), .chk_en(chk_en), .clr_err(clr_err), .load(load), .updown(updown),
    .data(data), .cnt_obs(cnt_obs), .exp_cnt(exp1), .mismatch(mm1), .err_flag(fl1),
    .err_count(ec1), .first_exp(fe1), .first_obs(fo1), .wrap(wr1), .state(st1));

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Reference model: checker state in plain integers, states 0/1/2 = idle/track/halt.
  typedef struct {
    int st;
    int ex;
    bit mm;
    bit wr;
    bit fl;
    int ec;
    int fe;
    int fo;
  } mdl_t;

  mdl_t m0, m1;
  int   cnt = 0;

  function automatic int nv(bit ld, bit up, int d, int v);
    return ld ? d : (v + (up ? 1 : 15)) % 16;
  endfunction

  function automatic bit wr_of(bit ld, bit up, int v);
    return !ld && (up ? (v == 15) : (v == 0));
  endfunction

  function automatic mdl_t step(mdl_t m, bit stop, bit r, bit en, bit clr, bit ld, bit up,
                                int d, int obs);
    mdl_t n = m;
    n.mm = 0;
    n.wr = 0;
    if (r) return '{0, 0, 0, 0, 0, 0, 0, 0};
    if (m.st == 0) begin
      n.ex = nv(ld, up, d, obs);
      if (en) n.st = 1;
    end else if (m.st == 1) begin
      if (!en) begin
        n.st = 0;
        n.ex = nv(ld, up, d, obs);
      end else if (obs == m.ex) begin
        n.ex = nv(ld, up, d, m.ex);
        n.wr = wr_of(ld, up, m.ex);
      end else begin
        n.mm = 1;
        n.fl = 1;
        n.ec = (m.ec < 255) ? m.ec + 1 : 255;
        if (!m.fl) begin
          n.fe = m.ex;
          n.fo = obs;
        end
        if (stop) n.st = 2;
        else begin
          n.ex = nv(ld, up, d, obs);
          n.wr = wr_of(ld, up, obs);
        end
      end
    end
    if (clr) begin
      n.ec = 0;
      n.fl = 0;
      n.fe = 0;
      n.fo = 0;
      if (n.st == 2) n.st = 0;
    end
    return n;
  endfunction

  task automatic cmp(input string who, input mdl_t m, input int st, input int ex, input int mm,
                     input int wr, input int fl, input int ec, input int fe, input int fo);
    check({who, ".state"}, st, m.st);
    check({who, ".exp_cnt"}, ex, m.ex);
    check({who, ".mismatch"}, mm, int'(m.mm));
    check({who, ".wrap"}, wr, int'(m.wr));
    check({who, ".err_flag"}, fl, int'(m.fl));
    check({who, ".err_count"}, ec, m.ec);
    check({who, ".first_exp"}, fe, m.fe);
    check({who, ".first_obs"}, fo, m.fo);
  endtask

  // Drives one edge; inj overwrites the counter register itself with injv.
  task automatic cycle(input bit r, input bit en, input bit clr, input bit ld, input bit up,
                       input int d, input bit inj, input int injv);
    int obs;
    obs     = inj ? injv : cnt;
    rst     = r;
    chk_en  = en;
    clr_err = clr;
    load    = ld;
    updown  = up;
    data    = d[3:0];
    cnt_obs = obs[3:0];
    m0  = step(m0, 1'b0, r, en, clr, ld, up, d, obs);
    m1  = step(m1, 1'b1, r, en, clr, ld, up, d, obs);
    cnt = r ? 0 : nv(ld, up, d, obs);
    @(posedge clk);
    @(negedge clk);
    cmp("run", m0, st0, exp0, mm0, wr0, fl0, ec0, fe0, fo0);
    cmp("halt", m1, st1, exp1, mm1, wr1, fl1, ec1, fe1, fo1);
    wraps0 += int'(wr0);
  endtask

  task automatic do_reset();
    cycle(1, 0, 0, 0, 1, 0, 0, 0);
    cycle(1, 0, 0, 0, 1, 0, 0, 0);
  endtask

  initial begin
    int fe_want, fo_want;
    m0 = '{0, 0, 0, 0, 0, 0, 0, 0};
    m1 = m0;
    @(negedge clk);

    // Free-running up count through one wrap.
    do_reset();
    check("reset.state", int'(st0), 0);
    check("reset.exp_cnt", int'(exp0), 0);
    wraps0 = 0;
    for (int i = 0; i < 20; i++) cycle(0, 1, 0, 0, 1, 0, 0, 0);
    check("t1.wraps", wraps0, 1);
    check("t1.err_count", int'(ec0), 0);

    // Load 0xA then count down across zero.
    wraps0 = 0;
    cycle(0, 1, 0, 1, 1, 10, 0, 0);
    for (int i = 0; i < 12; i++) cycle(0, 1, 0, 0, 0, 0, 0, 0);
    check("t2.wraps", wraps0, 1);
    check("t2.exp_cnt", int'(exp0), 14);

    // Single corruption while 3 is expected.
    do_reset();
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 1, 0, 1, 15);
    check("t3.mismatch", int'(mm0), 1);
    check("t3.first_exp", int'(fe0), 3);
    check("t3.first_obs", int'(fo0), 15);
    check("t4.halt_state", int'(st1), 2);
    cycle(0, 1, 0, 0, 1, 0, 1, 7);
    cycle(0, 1, 0, 0, 1, 0, 1, 9);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 1, 0, 0, 0);
    check("t4.halt_err_count", int'(ec1), 1);
    cycle(0, 1, 1, 0, 1, 0, 0, 0);
    check("t4.clr_state", int'(st1), 0);
    check("t4.clr_err_count", int'(ec1), 0);
    check("t4.clr_err_flag", int'(fl1), 0);

    // Mismatch every cycle until the error count saturates.
    do_reset();
    cycle(0, 1, 0, 0, 1, 0, 0, 0);
    fe_want = m0.ex;
    fo_want = (m0.ex + 5) % 16;
    cycle(0, 1, 0, 0, 1, 0, 1, fo_want);
    for (int i = 1; i < 300; i++)
      cycle(0, 1, 0, 0, 1, 0, 1, (m0.ex + 1 + $urandom_range(0, 14)) % 16);
    check("t5.err_count", int'(ec0), 255);
    check("t5.first_exp", int'(fe0), fe_want);
    check("t5.first_obs", int'(fo0), fo_want);

    // Reset mid-track, then clear coinciding with a mismatch.
    do_reset();
    cycle(0, 1, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0, 1, 0, 1, (m0.ex + 3) % 16);
    check("t6.err_count5", int'(ec0), 5);
    cycle(1, 1, 0, 0, 1, 0, 0, 0);
    check("t6.rst_state", int'(st0), 0);
    check("t6.rst_exp_cnt", int'(exp0), 0);
    check("t6.rst_err_count", int'(ec0), 0);
    cycle(0, 1, 0, 0, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 1, 0, 0, 0);
    cycle(0, 1, 1, 0, 1, 0, 1, (m0.ex + 8) % 16);
    check("t6.clr_mismatch", int'(mm0), 1);
    check("t6.clr_err_count", int'(ec0), 0);

    // Randomized traffic with occasional corruption, clears, resets and enable drops.
    for (int i = 0; i < 1500; i++)
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0, $urandom_range(0, 39) == 0,
            $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)), $urandom_range(0, 15),
            $urandom_range(0, 14) == 0, $urandom_range(0, 15));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
